mem_arbiter: RTL and testbench

- Shares one single-ported memory backend between the CPU instruction-fetch port and the data port.
- Used for the shared-memory CPU variant, where fetch and load/store cannot be served in the same cycle.
- Each requester uses a level req/ack handshake; the backend uses a req/done handshake.
- When both requesters collide, two-way round-robin arbitration decides the winner.

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter_rr_arb2.sv | 22 ++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: access size, error code, FSM state and port id.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        DtByte = 2'd0,
        DtHalf = 2'd1,
        DtWord = 2'd2
    } mem_dt_e;

    typedef enum logic [1:0] {
        ErrNone  = 2'd0,
        ErrBus   = 2'd1,
        ErrAlign = 2'd2,
        ErrPerm  = 2'd3
    } errno_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } arb_port_e;

    function automatic arb_port_e other_port(arb_port_e p);
        return (p == INSTR) ? DATA : INSTR;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester and backend signals around the arbiter.
// slave = arbiter view; master = requesters plus backend (environment) view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    import mem_arb_pkg::*;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rd;
    errno_e            i_err;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [DATA_W-1:0] d_wd;
    mem_dt_e           d_dt;
    logic              d_ack;
    logic [DATA_W-1:0] d_rd;
    errno_e            d_err;

    logic              m_req;
    logic [ADDR_W-1:0] m_addr;
    logic              m_we;
    logic [DATA_W-1:0] m_wd;
    mem_dt_e           m_dt;
    logic              m_done;
    logic [DATA_W-1:0] m_rd;
    errno_e            m_err;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_we, d_wd, d_dt, m_done, m_rd, m_err,
        output i_ack, i_rd, i_err, d_ack, d_rd, d_err, m_req, m_addr, m_we, m_wd, m_dt
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, d_we, d_wd, d_dt, m_done, m_rd, m_err,
        input  i_ack, i_rd, i_err, d_ack, d_rd, d_err, m_req, m_addr, m_we, m_wd, m_dt
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on collision the port that did not win last.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,      // bit 0 = INSTR, bit 1 = DATA
    input  arb_port_e  last_gnt_i,
    output logic       gnt_valid_o,
    output arb_port_e  gnt_port_o
);

    always_comb begin
        gnt_valid_o = |req_i;
        gnt_port_o  = INSTR;
        case (req_i)
            2'b01:   gnt_port_o = INSTR;
            2'b10:   gnt_port_o = DATA;
            2'b11:   gnt_port_o = other_port(last_gnt_i);
            default: gnt_port_o = INSTR;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory backend between the fetch port and the data port.
// Every access walks IDLE -> ISSUE -> RESP; all outputs are registered.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    arb_state_e        state_q,    state_d;
    arb_port_e         last_gnt_q, last_gnt_d;
    logic              m_req_q,    m_req_d;
    logic [ADDR_W-1:0] m_addr_q,   m_addr_d;
    logic              m_we_q,     m_we_d;
    logic [DATA_W-1:0] m_wd_q,     m_wd_d;
    mem_dt_e           m_dt_q,     m_dt_d;
    logic              i_ack_q,    i_ack_d;
    logic [DATA_W-1:0] i_rd_q,     i_rd_d;
    errno_e            i_err_q,    i_err_d;
    logic              d_ack_q,    d_ack_d;
    logic [DATA_W-1:0] d_rd_q,     d_rd_d;
    errno_e            d_err_q,    d_err_d;

    logic      gnt_valid;
    arb_port_e gnt_port;

    rr_arb2 u_rr_arb2 (
        .req_i       ({bus.d_req, bus.i_req}),
        .last_gnt_i  (last_gnt_q),
        .gnt_valid_o (gnt_valid),
        .gnt_port_o  (gnt_port)
    );

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        m_req_d    = m_req_q;
        m_addr_d   = m_addr_q;
        m_we_d     = m_we_q;
        m_wd_d     = m_wd_q;
        m_dt_d     = m_dt_q;
        i_ack_d    = 1'b0;
        i_rd_d     = i_rd_q;
        i_err_d    = i_err_q;
        d_ack_d    = 1'b0;
        d_rd_d     = d_rd_q;
        d_err_d    = d_err_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d    = ISSUE;
                    last_gnt_d = gnt_port;
                    m_req_d    = 1'b1;
                    if (gnt_port == DATA) begin
                        m_addr_d = bus.d_addr;
                        m_we_d   = bus.d_we;
                        m_wd_d   = bus.d_wd;
                        m_dt_d   = bus.d_dt;
                    end else begin
                        // Fetches are always plain word reads.
                        m_addr_d = bus.i_addr;
                        m_we_d   = 1'b0;
                        m_wd_d   = '0;
                        m_dt_d   = DtWord;
                    end
                end
            end
            ISSUE: begin
                if (bus.m_done && m_req_q) begin
                    state_d = RESP;
                    m_req_d = 1'b0;
                    // last_gnt doubles as the in-flight owner until the next grant.
                    if (last_gnt_q == DATA) begin
                        d_ack_d = 1'b1;
                        d_rd_d  = bus.m_rd;
                        d_err_d = bus.m_err;
                    end else begin
                        i_ack_d = 1'b1;
                        i_rd_d  = bus.m_rd;
                        i_err_d = bus.m_err;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= INSTR;
            m_req_q    <= 1'b0;
            m_addr_q   <= '0;
            m_we_q     <= 1'b0;
            m_wd_q     <= '0;
            m_dt_q     <= DtWord;
            i_ack_q    <= 1'b0;
            i_rd_q     <= '0;
            i_err_q    <= ErrNone;
            d_ack_q    <= 1'b0;
            d_rd_q     <= '0;
            d_err_q    <= ErrNone;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            m_req_q    <= m_req_d;
            m_addr_q   <= m_addr_d;
            m_we_q     <= m_we_d;
            m_wd_q     <= m_wd_d;
            m_dt_q     <= m_dt_d;
            i_ack_q    <= i_ack_d;
            i_rd_q     <= i_rd_d;
            i_err_q    <= i_err_d;
            d_ack_q    <= d_ack_d;
            d_rd_q     <= d_rd_d;
            d_err_q    <= d_err_d;
        end
    end

    assign bus.m_req  = m_req_q;
    assign bus.m_addr = m_addr_q;
    assign bus.m_we   = m_we_q;
    assign bus.m_wd   = m_wd_q;
    assign bus.m_dt   = m_dt_q;
    assign bus.i_ack  = i_ack_q;
    assign bus.i_rd   = i_rd_q;
    assign bus.i_err  = i_err_q;
    assign bus.d_ack  = d_ack_q;
    assign bus.d_rd   = d_rd_q;
    assign bus.d_err  = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model checked every cycle,
// plus hand-computed expectations for latency, ordering, data and errors.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_iack = 0;
    int   n_dack = 0;
    int   bk_stall = 0;
    errno_e bk_err = ErrNone;
    logic [31:0] bmem [logic [31:0]];

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: one open transaction at a time, acknowledged the cycle after completion.
    typedef struct packed {
        arb_port_e   port;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
        mem_dt_e     dt;
    } xact_t;

    xact_t       cur;
    bit          busy, ack_now;
    arb_port_e   ack_port, last, win;
    logic [31:0] exp_i_rd, exp_d_rd;
    errno_e      exp_i_err, exp_d_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy = 0; ack_now = 0; ack_port = INSTR; last = INSTR;
            cur.port = INSTR; cur.addr = 0; cur.we = 0; cur.wd = 0; cur.dt = DtWord;
            exp_i_rd = 0; exp_d_rd = 0; exp_i_err = ErrNone; exp_d_err = ErrNone;
        end else if (ack_now) begin
            ack_now = 0;
        end else if (busy) begin
            if (bus.m_done) begin
                busy = 0; ack_now = 1; ack_port = cur.port;
                if (cur.port == DATA) begin exp_d_rd = bus.m_rd; exp_d_err = bus.m_err; end
                else begin exp_i_rd = bus.m_rd; exp_i_err = bus.m_err; end
            end
        end else if (bus.i_req || bus.d_req) begin
            if (bus.i_req && bus.d_req) win = (last == INSTR) ? DATA : INSTR;
            else win = bus.d_req ? DATA : INSTR;
            cur.port = win;
            if (win == DATA) begin
                cur.addr = bus.d_addr; cur.we = bus.d_we; cur.wd = bus.d_wd; cur.dt = bus.d_dt;
            end else begin
                cur.addr = bus.i_addr; cur.we = 0; cur.wd = 0; cur.dt = DtWord;
            end
            busy = 1; last = win;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_req", bus.m_req, busy);
            chk("m_addr", bus.m_addr, cur.addr);
            chk("m_we", bus.m_we, cur.we);
            chk("m_wd", bus.m_wd, cur.wd);
            chk("m_dt", bus.m_dt, cur.dt);
            chk("i_ack", bus.i_ack, ack_now && ack_port == INSTR);
            chk("d_ack", bus.d_ack, ack_now && ack_port == DATA);
            chk("i_rd", bus.i_rd, exp_i_rd);
            chk("d_rd", bus.d_rd, exp_d_rd);
            chk("i_err", bus.i_err, exp_i_err);
            chk("d_err", bus.d_err, exp_d_err);
            if (bus.i_ack) n_iack++;
            if (bus.d_ack) n_dack++;
        end
    end

    // Backend: memory with programmable stall; junk on m_rd whenever m_done is low.
    int stall_cnt;
    initial begin
        bus.m_done = 0; bus.m_rd = 32'hdeadbeef; bus.m_err = ErrNone; stall_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (bus.m_done || !bus.m_req) begin
                bus.m_done = 0; bus.m_rd = 32'hdeadbeef; bus.m_err = ErrNone; stall_cnt = 0;
            end else if (stall_cnt < bk_stall) begin
                stall_cnt++;
                bus.m_err = bk_err;
            end else begin
                bus.m_done = 1; bus.m_err = bk_err;
                if (bus.m_we) begin
                    bmem[bus.m_addr] = bus.m_wd; bus.m_rd = 0;
                end else begin
                    bus.m_rd = bmem.exists(bus.m_addr) ? bmem[bus.m_addr] : 32'h0;
                end
            end
        end
    end

    task automatic wait_ack(input bit is_data, input int budget, output int cyc);
        cyc = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (is_data ? bus.d_ack : bus.i_ack) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic run_one(input bit is_data, input logic [31:0] addr, input bit we,
                           input logic [31:0] wd, input mem_dt_e dt, input int exp_lat,
                           input string tag);
        int cyc, ai, ad;
        @(posedge clk); #1;
        ai = n_iack; ad = n_dack;
        if (is_data) begin
            bus.d_req = 1; bus.d_addr = addr; bus.d_we = we; bus.d_wd = wd; bus.d_dt = dt;
        end else begin
            bus.i_req = 1; bus.i_addr = addr;
        end
        wait_ack(is_data, 40, cyc);
        chk({tag, "_latency"}, cyc, exp_lat);
        @(posedge clk); #1;
        bus.i_req = 0; bus.d_req = 0;
        chk({tag, "_ack_count"}, is_data ? n_dack - ad : n_iack - ai, 1);
        chk({tag, "_other_ack"}, is_data ? n_iack - ai : n_dack - ad, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1; #2 rst = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not end, %0d/%0d checks so far", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int ports[4];
        int cycs[4];
        int na, ai, ad;
        bus.i_req = 0; bus.i_addr = 0;
        bus.d_req = 0; bus.d_addr = 0; bus.d_we = 0; bus.d_wd = 0; bus.d_dt = DtWord;
        bmem[32'h4] = 32'h0002e233;
        bmem[32'h8] = 32'h12345678;
        rst = 0;
        #1 rst = 1;
        #2 rst = 0;
        #1;
        chk("rst_m_req", bus.m_req, 0);
        chk("rst_i_ack", bus.i_ack, 0);
        chk("rst_d_ack", bus.d_ack, 0);
        chk("rst_i_rd", bus.i_rd, 0);
        chk("rst_d_rd", bus.d_rd, 0);
        chk("rst_m_dt", bus.m_dt, DtWord);
        chk("rst_i_err", bus.i_err, ErrNone);
        chk("rst_state", dut.state_q, IDLE);

        run_one(0, 32'h4, 0, 0, DtWord, 2, "fetch");
        chk("fetch_rd", bus.i_rd, 32'h0002e233);
        chk("fetch_m_addr", bus.m_addr, 32'h4);
        chk("fetch_m_we", bus.m_we, 0);
        chk("fetch_m_dt", bus.m_dt, DtWord);

        run_one(1, 32'h10, 1, 32'hff, DtWord, 2, "store");
        chk("store_m_we", bus.m_we, 1);
        chk("store_m_wd", bus.m_wd, 32'hff);
        run_one(1, 32'h10, 0, 0, DtWord, 2, "load");
        chk("load_rd", bus.d_rd, 32'hff);
        chk("load_m_we", bus.m_we, 0);
        run_one(1, 32'h20, 1, 32'h5a, DtByte, 2, "store_b");
        chk("store_b_m_dt", bus.m_dt, DtByte);

        // Both requesters held high from reset: grants must alternate D, I, D, I.
        pulse_reset();
        @(posedge clk); #1;
        bus.i_req = 1; bus.i_addr = 32'h4;
        bus.d_req = 1; bus.d_addr = 32'h10; bus.d_we = 0; bus.d_wd = 0; bus.d_dt = DtWord;
        na = 0;
        for (int k = 0; k < 40 && na < 4; k++) begin
            @(negedge clk);
            if (bus.d_ack || bus.i_ack) begin
                ports[na] = bus.d_ack ? 1 : 0;
                cycs[na] = k;
                na++;
            end
        end
        @(posedge clk); #1;
        bus.i_req = 0; bus.d_req = 0;
        chk("coll_acks", na, 4);
        chk("coll_0_port", ports[0], 1); chk("coll_0_cyc", cycs[0], 2);
        chk("coll_1_port", ports[1], 0); chk("coll_1_cyc", cycs[1], 5);
        chk("coll_2_port", ports[2], 1); chk("coll_2_cyc", cycs[2], 8);
        chk("coll_3_port", ports[3], 0); chk("coll_3_cyc", cycs[3], 11);
        chk("coll_d_rd", bus.d_rd, 32'hff);
        chk("coll_i_rd", bus.i_rd, 32'h0002e233);

        bk_stall = 5; bk_err = ErrBus;
        run_one(0, 32'h8, 0, 0, DtWord, 7, "stall_fetch");
        chk("stall_fetch_err", bus.i_err, ErrBus);
        chk("stall_fetch_rd", bus.i_rd, 32'h12345678);
        bk_stall = 2; bk_err = ErrPerm;
        run_one(1, 32'h10, 0, 0, DtWord, 4, "stall_load");
        chk("stall_load_err", bus.d_err, ErrPerm);
        chk("stall_load_rd", bus.d_rd, 32'hff);
        bk_stall = 0; bk_err = ErrNone;
        run_one(0, 32'h4, 0, 0, DtWord, 2, "clean_fetch");
        chk("clean_fetch_err", bus.i_err, ErrNone);

        // Reset lands mid-ISSUE while the backend is stalling.
        bk_stall = 10;
        @(posedge clk); #1;
        bus.i_req = 1; bus.i_addr = 32'h8;
        @(negedge clk);
        @(negedge clk);
        chk("issue_m_req", bus.m_req, 1);
        #1 rst = 1;
        #1;
        chk("async_m_req", bus.m_req, 0);
        chk("async_m_addr", bus.m_addr, 0);
        chk("async_i_ack", bus.i_ack, 0);
        chk("async_i_rd", bus.i_rd, 0);
        #1 rst = 0;
        bus.i_req = 0;
        ai = n_iack; ad = n_dack;
        repeat (20) @(posedge clk);
        #1;
        chk("abandon_no_ack", (n_iack - ai) + (n_dack - ad), 0);
        bk_stall = 0;
        run_one(0, 32'h4, 0, 0, DtWord, 2, "post_rst");
        chk("post_rst_rd", bus.i_rd, 32'h0002e233);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
